// File: rtl/voice_pkg.sv
// Shared types for the polyphonic voice allocator: FSM states, sizing
// constants and the per-voice record held by each voice_slot.
package voice_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;

   localparam int MAX_VOICES   = 8;
   localparam int AGE_W        = 8;
   localparam int VOICE_FCCW_W = 30;

   typedef struct packed {
      logic                    held;
      logic [7:0]              code;
      logic [VOICE_FCCW_W-1:0] fccw;
      logic [AGE_W-1:0]        age;
   } voice_t;

endpackage

// File: rtl/voice_allocator_slot.sv
// One voice's bookkeeping: held flag, key code, fccw and a saturating age
// that counts allocations made to other voices since this one was loaded.
module voice_slot
   import voice_pkg::*;
(
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    load_i,
   input  logic                    release_i,
   input  logic                    age_inc_i,
   input  logic [7:0]              code_i,
   input  logic [VOICE_FCCW_W-1:0] fccw_i,
   output voice_t                  rec_o
);

   voice_t rec_q, rec_d;

   always_comb begin
      rec_d = rec_q;
      if (load_i) begin
         rec_d.held = 1'b1;
         rec_d.code = code_i;
         rec_d.fccw = fccw_i;
         rec_d.age  = '0;
      end else begin
         if (release_i)
            rec_d.held = 1'b0;
         if (age_inc_i && rec_q.age != '1)
            rec_d.age = rec_q.age + AGE_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) rec_q <= '0;
      else         rec_q <= rec_d;
   end

   assign rec_o = rec_q;

endmodule

// File: rtl/voice_allocator.sv
// Assigns key make/break events to voices: scans one voice per cycle, then
// issues a start (retrigger/free/oldest/steal) or a release in one cycle.
module voice_allocator
   import voice_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int FCCW_W     = VOICE_FCCW_W
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         key_valid_i,
   output logic                         key_ready_o,
   input  logic                         key_make_i,
   input  logic [7:0]                   key_code_i,
   input  logic [FCCW_W-1:0]            key_fccw_i,
   input  logic                         all_off_i,
   input  logic [NUM_VOICES-1:0]        voice_idle_i,
   output logic [NUM_VOICES-1:0]        voice_start_o,
   output logic [NUM_VOICES-1:0]        voice_release_o,
   output logic [NUM_VOICES*FCCW_W-1:0] voice_fccw_o,
   output logic [NUM_VOICES-1:0]        voice_held_o
);

   localparam int IDX_W = $clog2(NUM_VOICES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } match_t;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
      logic [AGE_W-1:0] age;
   } pick_t;

   state_t                state_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  make_q;
   logic [7:0]            code_q;
   logic [FCCW_W-1:0]     fccw_q;
   match_t                hit_q, hit_d, rel_q, rel_d, free_q, free_d;
   pick_t                 oldn_q, oldn_d, oldh_q, oldh_d;
   logic [NUM_VOICES-1:0] start_q, release_q, load, rel, age_inc;
   voice_t                rec [NUM_VOICES];
   logic                  cur_held, last, tgt_ok;
   logic [7:0]            cur_code;
   logic [AGE_W-1:0]      cur_age;
   logic [IDX_W-1:0]      tgt;

   always_comb begin
      cur_held = rec[idx_q].held;
      cur_code = rec[idx_q].code;
      cur_age  = rec[idx_q].age;
      hit_d    = hit_q;
      rel_d    = rel_q;
      free_d   = free_q;
      oldn_d   = oldn_q;
      oldh_d   = oldh_q;
      if (cur_code == code_q && cur_held && !hit_q.found)
         hit_d = '{1'b1, idx_q};
      if (cur_code == code_q && !cur_held && !rel_q.found)
         rel_d = '{1'b1, idx_q};
      if (!cur_held && voice_idle_i[idx_q] && !free_q.found)
         free_d = '{1'b1, idx_q};
      // strict compare keeps the lowest index on equal ages
      if (!cur_held && (!oldn_q.found || cur_age > oldn_q.age))
         oldn_d = '{1'b1, idx_q, cur_age};
      if (cur_held && (!oldh_q.found || cur_age > oldh_q.age))
         oldh_d = '{1'b1, idx_q, cur_age};

      tgt_ok = !hit_d.found;
      if (rel_d.found)       tgt = rel_d.idx;
      else if (free_d.found) tgt = free_d.idx;
      else if (oldn_d.found) tgt = oldn_d.idx;
      else                   tgt = oldh_d.idx;

      last = (state_q == SCAN) && (idx_q == LAST_IDX);
      for (int i = 0; i < NUM_VOICES; i++) begin
         load[i]    = last && make_q && tgt_ok && (tgt == IDX_W'(i)) && !all_off_i;
         age_inc[i] = last && make_q && tgt_ok && (tgt != IDX_W'(i)) && !all_off_i;
         rel[i]     = all_off_i ? rec[i].held
                    : (last && !make_q && hit_d.found && hit_d.idx == IDX_W'(i));
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         make_q    <= 1'b0;
         code_q    <= '0;
         fccw_q    <= '0;
         hit_q     <= '0;
         rel_q     <= '0;
         free_q    <= '0;
         oldn_q    <= '0;
         oldh_q    <= '0;
         start_q   <= '0;
         release_q <= '0;
      end else begin
         start_q   <= load;
         release_q <= rel;
         if (all_off_i) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: if (key_valid_i) begin
                  make_q  <= key_make_i;
                  code_q  <= key_code_i;
                  fccw_q  <= key_fccw_i;
                  idx_q   <= '0;
                  hit_q   <= '0;
                  rel_q   <= '0;
                  free_q  <= '0;
                  oldn_q  <= '0;
                  oldh_q  <= '0;
                  state_q <= SCAN;
               end
               SCAN: begin
                  hit_q  <= hit_d;
                  rel_q  <= rel_d;
                  free_q <= free_d;
                  oldn_q <= oldn_d;
                  oldh_q <= oldh_d;
                  idx_q  <= idx_q + 1'b1;
                  if (idx_q == LAST_IDX) state_q <= ISSUE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign key_ready_o     = (state_q == IDLE) && !all_off_i;
   assign voice_start_o   = start_q;
   assign voice_release_o = release_q;

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
      voice_slot u_slot (
         .clk_i     (clk_i),
         .reset_i   (reset_i),
         .load_i    (load[g]),
         .release_i (rel[g]),
         .age_inc_i (age_inc[g]),
         .code_i    (code_q),
         .fccw_i    (VOICE_FCCW_W'(fccw_q)),
         .rec_o     (rec[g])
      );
      assign voice_fccw_o[g*FCCW_W +: FCCW_W] = FCCW_W'(rec[g].fccw);
      assign voice_held_o[g]                  = rec[g].held;
   end

endmodule
